// File: rtl/secksa_arb.sv
// secksa_arb: two-port arbiter and in-flight tag tracker sharing one masked SecKSA pipeline.
// Define SECKSA_ARB_PRIO_EN for fixed priority (r0 always wins); default is round-robin.
module secksa_arb #(
    parameter int K_WIDTH   = 32,
    parameter int N_SHARES  = 3,
    parameter int MASKWIDTH = K_WIDTH * N_SHARES,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   r0_vld,
    input  logic                   r1_vld,
    output logic                   r0_rdy,
    output logic                   r1_rdy,
    input  logic [MASKWIDTH-1:0]   r0_x,
    input  logic [MASKWIDTH-1:0]   r0_y,
    input  logic [MASKWIDTH-1:0]   r1_x,
    input  logic [MASKWIDTH-1:0]   r1_y,
    output logic                   ksa_dvld,
    output logic                   ksa_ena,
    output logic [MASKWIDTH-1:0]   ksa_x,
    output logic [MASKWIDTH-1:0]   ksa_y,
    input  logic [MASKWIDTH-1:0]   ksa_z,
    input  logic                   ksa_ovld,
    output logic                   rsp_vld0,
    output logic                   rsp_vld1,
    output logic [MASKWIDTH-1:0]   rsp_z,
    output logic [$clog2(DEPTH):0] inflight,
    output logic                   err
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic             can_grant;
    logic             grant0;
    logic             grant1;
    logic             grant;
    logic             pop;
    logic             empty;
    logic             full;
    logic             head_tag;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] tag_mem;

    assign ksa_ena   = ~stall;
    assign full      = (inflight == FULL_CNT);
    assign empty     = (inflight == '0);
    // Eligibility looks at the registered count only, so a same-cycle pop never frees a slot early.
    assign can_grant = ~stall & ~full;

`ifdef SECKSA_ARB_PRIO_EN
    assign grant0 = can_grant & r0_vld;
    assign grant1 = can_grant & r1_vld & ~r0_vld;
`else
    logic lg;

    assign grant0 = can_grant & r0_vld & (~r1_vld | lg);
    assign grant1 = can_grant & r1_vld & (~r0_vld | ~lg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     lg <= 1'b1;
        else if (grant) lg <= grant1;
    end
`endif

    assign grant    = grant0 | grant1;
    assign r0_rdy   = grant0;
    assign r1_rdy   = grant1;
    assign pop      = ksa_ovld & ksa_ena & ~empty;
    assign head_tag = tag_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ksa_dvld <= 1'b0;
            ksa_x    <= '0;
            ksa_y    <= '0;
        end else begin
            // dvld holds through a stall so the adder still sees the launch when enable returns.
            if (!stall) ksa_dvld <= grant;
            if (grant) begin
                ksa_x <= grant1 ? r1_x : r0_x;
                ksa_y <= grant1 ? r1_y : r0_y;
            end
        end
    end

    // NOTE: tag storage is left unreset; an entry is only read after it has been written, and
    // the reset pointers/count already mark every slot empty.
    always_ff @(posedge clk) begin
        if (grant) tag_mem[wr_ptr] <= grant1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
            err      <= 1'b0;
            rsp_vld0 <= 1'b0;
            rsp_vld1 <= 1'b0;
            rsp_z    <= '0;
        end else begin
            if (grant) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({grant, pop})
                2'b10:   inflight <= inflight + CNT_ONE;
                2'b01:   inflight <= inflight - CNT_ONE;
                default: inflight <= inflight;
            endcase
            if ((ksa_ovld & ksa_ena & empty) | (grant & full)) err <= 1'b1;
            rsp_vld0 <= pop & ~head_tag;
            rsp_vld1 <= pop & head_tag;
            if (pop) rsp_z <= ksa_z;
        end
    end
endmodule

// File: doc/secksa_arb.md
# secksa_arb

Two-port round-robin arbiter and in-flight tracker that shares one masked Kogge-Stone adder (SecKSA) pipeline between two requesters in the B2A conversion path. It accepts masked operand pairs (x, y, each N_SHARES Boolean shares) over valid/ready handshakes and registers the selected pair into the adder. A tag FIFO records which requester owns each in-flight operation, so every masked sum returns to the correct requester. The block does not need to know the adder latency: responses are matched in order using the adder's ovld.

## Interface
- K_WIDTH, 32, bit width of each share
- N_SHARES, 3, number of Boolean shares
- MASKWIDTH, K_WIDTH*N_SHARES, width of a masked operand
- DEPTH, 16, maximum in-flight operations (tag FIFO depth, power of two, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  global hold; freezes arbiter, FIFO and adder
- r0_vld / r1_vld  in  1  requester operand valid
- r0_rdy / r1_rdy  out  1  requester grant (combinational)
- r0_x, r0_y / r1_x, r1_y  in  MASKWIDTH  masked operands
- ksa_dvld  out  1  launch valid to adder
- ksa_ena  out  1  adder enable, equal to ~stall
- ksa_x, ksa_y  out  MASKWIDTH  launched operands
- ksa_z  in  MASKWIDTH  adder masked sum
- ksa_ovld  in  1  adder output valid
- rsp_vld0 / rsp_vld1  out  1  response valid per requester (no backpressure)
- rsp_z  out  MASKWIDTH  registered masked sum
- inflight  out  $clog2(DEPTH)+1  current occupancy
- err  out  1  sticky protocol error

## Operation
- Grant condition: stall=0 and inflight<DEPTH. Under this condition, at most one rN_rdy is high per cycle.
- Round-robin arbitration: the last-granted pointer `lg` resets to 1, so r0 wins the first contention.
  - Both valid: grant the requester ≠ lg.
  - One valid: grant that requester.
  - `lg` updates on every grant.
- Launch stage: on a handshake (rN_vld & rN_rdy), register the operands and assert ksa_dvld=1 for exactly one cycle. Push the tag (N) into the FIFO in the same cycle.
- Return stage: pop the FIFO head when ksa_ovld & ksa_ena. Next cycle, register rsp_z=ksa_z and assert rsp_vld<tag> for one cycle.
- inflight counter:
  - +1 on grant, −1 on pop.
  - Grant and pop in the same cycle leave it unchanged.
  - It counts operations from grant until pop.
- Stall:
  - ksa_ena=0, rdy low, FIFO and counter frozen.
  - ksa_dvld is held (not cleared) so the adder sees a stable input when enable returns.
  - ksa_ovld is ignored while stalled.
- err is set (and held until reset) on either condition:
  - ksa_ovld & ksa_ena while the FIFO is empty (the pop is suppressed);
  - a push attempted while the FIFO is full (unreachable by construction; checked anyway).
- Shares are passed through untouched. The block never combines or unmasks shares, and never drives one share as a function of another.
- Mid-operation reset: all in-flight operations are discarded. The adder shares rst_n, so no stale ovld appears after reset.

## Timing
- Reset values:
  - ksa_dvld, ksa_x, ksa_y, rsp_vld0, rsp_vld1, rsp_z, inflight, err all 0;
  - FIFO empty; lg=1;
  - ksa_ena follows ~stall combinationally.
- Latency:
  - Handshake at cycle t → ksa_dvld at t+1.
  - Response at (cycle of the matching ksa_ovld) + 1.
  - Total latency = L_KSA + 2 cycles when no stall occurs.
- Throughput: one launch per cycle sustained. Both requesters continuously valid → grants alternate r0, r1, r0, …
- Full: when inflight==DEPTH, both rdy are low. If a pop occurs in the same cycle, rdy remains low that cycle (grant eligibility uses registered inflight only).
- FIFO read/write pointers wrap modulo DEPTH.

## Configuration
- SECKSA_ARB_PRIO_EN defined: fixed priority. r0 always wins contention; lg is unused.
- SECKSA_ARB_PRIO_EN undefined: round-robin as specified above (default).

## Test plan
All cases use K=32, N=3, DEPTH=16 and a real SecKSA behind the block. Masked value = XOR of the shares.

- Single op: r0 sends x=(5,0,0), y=(3,0,0). Expected: ksa_dvld one cycle after the handshake; rsp_vld0 pulses once L_KSA+2 cycles after the handshake; XOR of rsp_z shares = 0x00000008; rsp_vld1 stays 0.
- Contention: r0 and r1 valid every cycle with 8 random masked pairs each. Expected: grants alternate starting with r0; each response unmasks to the 32-bit modular sum and is routed to its owner, in order.
- Full: hold the adder output by keeping stall=0 and r0 valid for 16 launches, while the bench forces ksa_ovld=0. Expected: inflight=16 and r0_rdy=0 thereafter. Then release ovld and observe one response per cycle.
- Stall: assert stall for 5 cycles mid-stream. Expected: ksa_ena=0, no grants, inflight unchanged, no rsp_vld during the stall; results remain correct afterward.
- Error: inject ksa_ovld=1 with an empty FIFO. Expected: err=1 next cycle and held until rst_n; no rsp_vld.
- Reset: assert rst_n=0 with 4 operations in flight. Expected: all outputs at reset values, and no response appears after deassertion.
